// File: rtl/throttle_curve_pipe.sv
// rtl/throttle_curve_pipe.sv - piecewise-linear throttle shaping with per-channel slew limiting
// Three-stage pipeline: table lookup, segment slope multiply, interpolate and clamp.
module throttle_curve_pipe #(
  parameter int DATA_W   = 8,
  parameter int SEG_BITS = 3,
  parameter int CHANNELS = 4,
  parameter int MAX_STEP = 0,
  localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [CH_W-1:0]     in_ch,
  input  logic [DATA_W-1:0]   in_throttle,
  input  logic                cfg_we,
  input  logic [SEG_BITS:0]   cfg_addr,
  input  logic [DATA_W-1:0]   cfg_data,
  output logic                out_valid,
  output logic [CH_W-1:0]     out_ch,
  output logic [DATA_W-1:0]   out_pwm,
  output logic                out_limited
);

  localparam int N_SEG = 1 << SEG_BITS;
  localparam int F     = DATA_W - SEG_BITS;
  localparam int PW    = DATA_W + F + 2;
  localparam logic [DATA_W-1:0] MAX_V     = '1;
  localparam logic [SEG_BITS:0] LAST_ADDR = (SEG_BITS+1)'(N_SEG);
  localparam logic [CH_W:0]     CH_LIM    = (CH_W+1)'(CHANNELS);
  localparam logic [DATA_W:0]   STEP      = (DATA_W+1)'(MAX_STEP);

  function automatic logic [DATA_W-1:0] ident(input int k);
    int v;
    v = k << F;
    return (v > int'(MAX_V)) ? MAX_V : DATA_W'(v);
  endfunction

  logic [DATA_W-1:0] y    [0:N_SEG];
  logic [DATA_W-1:0] prev [CHANNELS];

  // stage 1 registers
  logic              v1;
  logic [CH_W-1:0]   ch1;
  logic [DATA_W-1:0] y0_1, y1_1;
  logic [F-1:0]      frac1;
  // stage 2 registers
  logic              v2;
  logic [CH_W-1:0]   ch2;
  logic [DATA_W-1:0] y0_2;
  logic signed [PW-1:0] p2;

  logic [SEG_BITS:0]    seg_lo, seg_hi;
  logic                 in_ok;
  logic signed [DATA_W:0] d_c;
  logic signed [PW-1:0] prod_c;
  logic signed [PW-1:0] interp_w;
  logic [DATA_W-1:0]    interp, prev_c, lo_c, hi_c, res_c;
  logic [DATA_W:0]      hi_w;
  logic                 lim_c;
  logic                 unused_bits;

  assign seg_lo = {1'b0, in_throttle[DATA_W-1 -: SEG_BITS]};
  assign seg_hi = seg_lo + {{SEG_BITS{1'b0}}, 1'b1};
  assign in_ok  = in_valid && ({1'b0, in_ch} < CH_LIM);

  assign d_c    = $signed({1'b0, y1_1}) - $signed({1'b0, y0_1});
  assign prod_c = PW'(d_c) * PW'($signed({1'b0, frac1}));

  // Arithmetic shift floors toward minus infinity, keeping the result inside the segment.
  assign interp_w    = $signed({{(PW-DATA_W){1'b0}}, y0_2}) + (p2 >>> F);
  assign interp      = interp_w[DATA_W-1:0];
  assign unused_bits = ^interp_w[PW-1:DATA_W];

  always_comb begin
    prev_c = prev[ch2];
    hi_w   = {1'b0, prev_c} + STEP;
    hi_c   = hi_w[DATA_W] ? MAX_V : hi_w[DATA_W-1:0];
    lo_c   = ({1'b0, prev_c} >= STEP) ? (prev_c - STEP[DATA_W-1:0]) : '0;
    res_c  = interp;
    if (MAX_STEP > 0) begin
      if (interp < lo_c) res_c = lo_c;
      else if (interp > hi_c) res_c = hi_c;
    end
    lim_c = (res_c != interp);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1          <= 1'b0;
      v2          <= 1'b0;
      out_valid   <= 1'b0;
      out_ch      <= '0;
      out_pwm     <= '0;
      out_limited <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) prev[c] <= '0;
      for (int k = 0; k <= N_SEG; k++) y[k] <= ident(k);
    end else begin
      v1    <= in_ok;
      ch1   <= in_ch;
      y0_1  <= y[seg_lo];
      y1_1  <= y[seg_hi];
      frac1 <= in_throttle[F-1:0];

      v2    <= v1;
      ch2   <= ch1;
      y0_2  <= y0_1;
      p2    <= prod_c;

      out_valid <= v2;
      if (v2) begin
        out_ch      <= ch2;
        out_pwm     <= res_c;
        out_limited <= lim_c;
        prev[ch2]   <= res_c;
      end

      // Stage 1 samples this edge captured the old entry; the new one is seen next cycle.
      if (cfg_we && (cfg_addr <= LAST_ADDR)) y[cfg_addr] <= cfg_data;
    end
  end

endmodule

// File: tb/tb_throttle_curve_pipe.sv
// tb/tb_throttle_curve_pipe.sv - scoreboard bench for throttle_curve_pipe
// Three instances share stimulus: defaults, slew-limited (16), and three channels.
module tb_throttle_curve_pipe;

  typedef struct {
    int pwm;
    int ch;
    bit lim;
    int cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [1:0] in_ch = '0;
  logic [7:0] in_throttle = '0;
  logic       cfg_we = 1'b0;
  logic [3:0] cfg_addr = '0;
  logic [7:0] cfg_data = '0;

  logic       ov   [3];
  logic [1:0] och  [3];
  logic [7:0] opwm [3];
  logic       olim [3];

  int   cyc = 0;
  int   tests_run = 0;
  int   tests_failed = 0;
  bit   mon_en = 1'b0;
  exp_t q [3][$];
  exp_t me;
  int   ymod [9];
  int   prevm [3][4];
  int   nch [3];
  int   mstep [3];
  int   last_pwm [3];
  int   last_ch [3];
  bit   last_lim [3];

  throttle_curve_pipe #(.CHANNELS(4)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ch(in_ch), .in_throttle(in_throttle),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .out_valid(ov[0]), .out_ch(och[0]), .out_pwm(opwm[0]), .out_limited(olim[0]));

  throttle_curve_pipe #(.CHANNELS(4), .MAX_STEP(16)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ch(in_ch), .in_throttle(in_throttle),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .out_valid(ov[1]), .out_ch(och[1]), .out_pwm(opwm[1]), .out_limited(olim[1]));

  throttle_curve_pipe #(.CHANNELS(3)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ch(in_ch), .in_throttle(in_throttle),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .out_valid(ov[2]), .out_ch(och[2]), .out_pwm(opwm[2]), .out_limited(olim[2]));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mon_en) begin
      for (int i = 0; i < 3; i++) begin
        while (q[i].size() > 0 && q[i][0].cyc < cyc) begin
          me = q[i].pop_front();
          tests_run++; tests_failed++;
          $display("FAIL missing_out dut%0d: no output at cycle %0d, expected pwm=%0d", i, me.cyc, me.pwm);
        end
        if (ov[i]) begin
          tests_run++;
          if (q[i].size() == 0) begin
            tests_failed++;
            $display("FAIL unexpected_out dut%0d: got pwm=%0d ch=%0d at cycle %0d, expected no output", i, opwm[i], och[i], cyc);
          end else begin
            me = q[i].pop_front();
            if (me.cyc != cyc || opwm[i] !== me.pwm[7:0] || och[i] !== me.ch[1:0] || olim[i] !== me.lim) begin
              tests_failed++;
              $display("FAIL output dut%0d: got pwm=%0d ch=%0d lim=%0d cyc=%0d, expected pwm=%0d ch=%0d lim=%0d cyc=%0d",
                       i, opwm[i], och[i], olim[i], cyc, me.pwm, me.ch, me.lim, me.cyc);
            end
            last_pwm[i] = me.pwm; last_ch[i] = me.ch; last_lim[i] = me.lim;
          end
        end else if (q[i].size() > 0 && q[i][0].cyc == cyc) begin
          me = q[i].pop_front();
          tests_run++; tests_failed++;
          $display("FAIL missing_out dut%0d: out_valid=0 at cycle %0d, expected pwm=%0d", i, cyc, me.pwm);
        end else begin
          tests_run++;
          if (opwm[i] !== last_pwm[i][7:0] || och[i] !== last_ch[i][1:0] || olim[i] !== last_lim[i]) begin
            tests_failed++;
            $display("FAIL hold dut%0d: got pwm=%0d ch=%0d lim=%0d, expected pwm=%0d ch=%0d lim=%0d",
                     i, opwm[i], och[i], olim[i], last_pwm[i], last_ch[i], last_lim[i]);
          end
        end
      end
    end
  end

  task automatic model_reset();
    for (int k = 0; k < 9; k++) ymod[k] = (k * 32 > 255) ? 255 : k * 32;
    for (int i = 0; i < 3; i++) begin
      for (int c = 0; c < 4; c++) prevm[i][c] = 0;
      last_pwm[i] = 0; last_ch[i] = 0; last_lim[i] = 1'b0;
    end
  endtask

  task automatic drive(input bit v, input int ch, input int thr, input bit we, input int addr, input int data);
    int   seg, frac, p, fl, ip, o, lo, hi;
    exp_t e;
    in_valid = v; in_ch = 2'(ch); in_throttle = 8'(thr);
    cfg_we = we; cfg_addr = 4'(addr); cfg_data = 8'(data);
    if (v && !rst) begin
      seg  = thr / 32;
      frac = thr % 32;
      p    = (ymod[seg+1] - ymod[seg]) * frac;
      fl   = (p >= 0) ? p / 32 : -((-p + 31) / 32);
      ip   = ymod[seg] + fl;
      for (int i = 0; i < 3; i++) begin
        if (ch < nch[i]) begin
          o = ip;
          if (mstep[i] > 0) begin
            lo = prevm[i][ch] - mstep[i]; if (lo < 0) lo = 0;
            hi = prevm[i][ch] + mstep[i]; if (hi > 255) hi = 255;
            if (o < lo) o = lo;
            if (o > hi) o = hi;
          end
          e.pwm = o; e.ch = ch; e.lim = (o != ip); e.cyc = cyc + 3;
          q[i].push_back(e);
          prevm[i][ch] = o;
        end
      end
    end
    if (we && addr <= 8) ymod[addr] = data;
    @(posedge clk); #1;
    in_valid = 1'b0; cfg_we = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset(input bit with_sample);
    rst = 1'b1;
    if (with_sample) begin in_valid = 1'b1; in_ch = 2'd2; in_throttle = 8'd200; end
    for (int i = 0; i < 3; i++)
      while (q[i].size() > 0 && q[i][q[i].size()-1].cyc > cyc) void'(q[i].pop_back());
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    model_reset();
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((q[0].size() + q[1].size() + q[2].size()) > 0 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    tests_run++;
    if ((q[0].size() + q[1].size() + q[2].size()) != 0) begin
      tests_failed++;
      $display("FAIL drain_%s: %0d results still pending, expected 0", name, q[0].size() + q[1].size() + q[2].size());
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (ov[i] !== 1'b0 || och[i] !== 2'd0 || opwm[i] !== 8'd0 || olim[i] !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_state dut%0d: got v=%0d ch=%0d pwm=%0d lim=%0d, expected all 0", i, ov[i], och[i], opwm[i], olim[i]);
      end
    end
  endtask

  task automatic test_identity();
    int vals [5] = '{0, 12, 100, 240, 255};
    foreach (vals[k]) begin
      drive(1'b1, 0, vals[k], 1'b0, 0, 0);
      idle(1);
    end
    wait_drain("identity");
  endtask

  task automatic test_reprogram();
    drive(1'b1, 1, 16, 1'b1, 1, 128);
    drive(1'b1, 1, 16, 1'b0, 0, 0);
    drive(1'b0, 0, 0, 1'b1, 9, 0);
    drive(1'b1, 0, 40, 1'b0, 0, 0);
    wait_drain("reprogram");
  endtask

  task automatic test_floor();
    drive(1'b0, 0, 0, 1'b1, 0, 100);
    drive(1'b0, 0, 0, 1'b1, 1, 0);
    drive(1'b1, 0, 1, 1'b0, 0, 0);
    wait_drain("floor");
    do_reset(1'b0);
  endtask

  task automatic test_back_to_back_slew();
    do_reset(1'b0);
    drive(1'b1, 2, 200, 1'b0, 0, 0);
    drive(1'b1, 2, 200, 1'b0, 0, 0);
    drive(1'b1, 2, 200, 1'b0, 0, 0);
    drive(1'b1, 3, 10, 1'b0, 0, 0);
    drive(1'b1, 2, 200, 1'b0, 0, 0);
    drive(1'b1, 3, 20, 1'b0, 0, 0);
    wait_drain("slew");
  endtask

  task automatic test_invalid_ch();
    drive(1'b1, 3, 50, 1'b0, 0, 0);
    idle(2);
    drive(1'b1, 2, 50, 1'b0, 0, 0);
    wait_drain("invalid_ch");
  endtask

  task automatic test_midstream_reset();
    drive(1'b0, 0, 0, 1'b1, 3, 0);
    drive(1'b1, 2, 200, 1'b0, 0, 0);
    drive(1'b1, 0, 60, 1'b0, 0, 0);
    drive(1'b1, 1, 90, 1'b0, 0, 0);
    do_reset(1'b1);
    idle(5);
    drive(1'b1, 2, 200, 1'b0, 0, 0);
    drive(1'b1, 0, 100, 1'b0, 0, 0);
    wait_drain("midstream_reset");
  endtask

  initial begin
    nch[0] = 4; nch[1] = 4; nch[2] = 3;
    mstep[0] = 0; mstep[1] = 16; mstep[2] = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1'b1;
    test_reset();
    test_identity();
    test_reprogram();
    test_floor();
    test_back_to_back_slew();
    test_invalid_ch();
    test_midstream_reset();
    idle(4);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/throttle_curve_pipe.md
THROTTLE_CURVE_PIPE -- requirements
Module: throttle_curve_pipe

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, giving the throttle and PWM sample width.
REQ-002 The block SHALL have parameter SEG_BITS, default 3, giving N_SEG = 2^SEG_BITS uniform segments and F = DATA_W-SEG_BITS fraction bits.
REQ-003 The block SHALL have parameter CHANNELS, default 4, giving the number of motor channels; CH_W = max(1, clog2(CHANNELS)).
REQ-004 The block SHALL have parameter MAX_STEP, default 0, giving the per-channel slew limit per output sample, where 0 disables limiting.
REQ-005 The block SHALL have port clk, input, 1 bit, the single clock; all logic is on the rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-007 The block SHALL have port in_valid, input, 1 bit, sample strobe; there is no ready signal and a sample is accepted every cycle.
REQ-008 The block SHALL have port in_ch, input, CH_W bits, channel index of the sample.
REQ-009 The block SHALL have port in_throttle, input, DATA_W bits, unsigned throttle value.
REQ-010 The block SHALL have port cfg_we, input, 1 bit, breakpoint table write strobe.
REQ-011 The block SHALL have port cfg_addr, input, SEG_BITS+1 bits, breakpoint index 0..N_SEG.
REQ-012 The block SHALL have port cfg_data, input, DATA_W bits, breakpoint value.
REQ-013 The block SHALL have port out_valid, output, 1 bit, result strobe.
REQ-014 The block SHALL have port out_ch, output, CH_W bits, channel of the result.
REQ-015 The block SHALL have port out_pwm, output, DATA_W bits, shaped and slew-limited PWM value.
REQ-016 The block SHALL have port out_limited, output, 1 bit, high with out_valid when the slew clamp altered the result.

Function
REQ-017 The block SHALL hold a shared table y[0..N_SEG] of N_SEG+1 unsigned DATA_W-bit breakpoints.
REQ-018 Stage 1 SHALL compute seg = in_throttle[DATA_W-1 -: SEG_BITS] and frac = in_throttle[F-1:0], and register y[seg], y[seg+1], frac and ch.
REQ-019 Stage 2 SHALL compute d = y[seg+1]-y[seg] as a signed DATA_W+1-bit value and register p = d*frac at full signed width.
REQ-020 Stage 3 SHALL compute interp = y[seg] + (p >>> F), using an arithmetic shift (floor); the result always lies between y[seg] and y[seg+1], so no clipping is needed.
REQ-021 Stage 3 SHALL apply the slew limit when MAX_STEP>0: out = clamp(interp, max(0, prev[ch]-MAX_STEP), min(2^DATA_W-1, prev[ch]+MAX_STEP)), then write prev[ch] = out.
REQ-022 When MAX_STEP=0, out SHALL equal interp, out_limited SHALL be 0, and prev[ch] SHALL still be updated.
REQ-023 Latency SHALL be 3 cycles: a sample with in_valid in cycle N appears with out_valid in cycle N+3.
REQ-024 Throughput SHALL be one sample per cycle; out_valid SHALL be a pure delayed copy of the accepted in_valid.
REQ-025 A sample with in_ch >= CHANNELS SHALL be dropped: no out_valid and no prev update.
REQ-026 Back-to-back samples on the same channel SHALL each be limited against the immediately preceding result for that channel, with no stale prev.
REQ-027 A cfg_we in cycle N SHALL update y[cfg_addr] at the end of cycle N.
REQ-028 A sample with in_valid in cycle N SHALL read the pre-write table, and samples from cycle N+1 onward SHALL read the new value; samples already past stage 1 are unaffected.
REQ-029 A cfg_we with cfg_addr > N_SEG SHALL be ignored.
REQ-030 When out_valid=0, out_ch, out_pwm and out_limited SHALL hold their last values.

Reset
REQ-031 While rst=1 the block SHALL clear all pipeline valids and set out_valid=0, out_ch=0, out_pwm=0, out_limited=0.
REQ-032 While rst=1 every prev[ch] SHALL be set to 0.
REQ-033 While rst=1 the table SHALL be set to identity: y[k] = min(k*2^F, 2^DATA_W-1); for the defaults this is 0,32,...,224,255.
REQ-034 A reset asserted mid-stream SHALL discard all in-flight samples, with no out_valid in the following cycles.
REQ-035 Samples with in_valid=1 in the same cycle as rst=1 SHALL be ignored.

Verification
REQ-036 Bench SHALL cover identity table (defaults): in=0,12,100,240,255 on ch0, each 1-cycle valid -> out_pwm 0,12,100,239,254 exactly 3 cycles later, with out_limited=0.
REQ-037 Bench SHALL cover reprogramming: write y[1]=128, then in=16 on ch1 -> interp = 0+(128*16>>5) = 64; a sample issued in the write cycle itself still gets 16.
REQ-038 Bench SHALL cover decreasing-curve floor: y[0]=100, y[1]=0, in=1 -> 100 + floor(-100/32) = 96.
REQ-039 Bench SHALL cover slew limiting with MAX_STEP=16: ch2 in=200 over three consecutive cycles -> out_pwm 16, 32, 48, all with out_limited=1; ch3 is interleaved and unaffected.
REQ-040 Bench SHALL cover invalid channel with CHANNELS=3: in_ch=3 -> no out_valid; then in_ch=2 -> normal output.
REQ-041 Bench SHALL cover mid-stream reset: pulse rst for 1 cycle while 3 samples are in flight -> zero out_valid afterwards, table back to identity, and prev cleared (next limited output starts from 0).
